// File: rtl/scan_ctrl_pkg.sv
// Shared widths, default parameters and FSM encoding for the SET scan controller.
package scan_ctrl_pkg;

    localparam int unsigned DEF_GRID_DIM = 8;
    localparam int unsigned DEF_CNT_SZ   = 7;
    localparam int unsigned ROW_SZ       = 4;
    localparam int unsigned COORD_SZ     = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_ctrl.sv
// Sequences coord_gen over the grid in two-row bursts and counts the membership hits.
// All outputs are registered; next-state logic computes the value each output takes next cycle.
module scan_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned GRID_DIM = DEF_GRID_DIM,
    parameter int unsigned CNT_SZ   = DEF_CNT_SZ
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              hit_i,
    output logic [ROW_SZ-1:0] start_row_o,
    output logic              coord_en_o,
    output logic              busy_o,
    output logic [CNT_SZ-1:0] candidate_o,
    output logic              valid_o
);

    localparam int unsigned PT_SZ    = $clog2(GRID_DIM * GRID_DIM);
    localparam int unsigned BURST_SZ = $clog2(2 * GRID_DIM);

    scan_state_e       state_q, state_d;
    logic [PT_SZ-1:0]  pt_q, pt_d;
    logic [CNT_SZ-1:0] hits_q, hits_d;
    logic [ROW_SZ-1:0] start_row_q, start_row_d;
    logic              coord_en_q, coord_en_d;
    logic              busy_q, busy_d;
    logic [CNT_SZ-1:0] cand_q, cand_d;
    logic              valid_q, valid_d;

    logic [PT_SZ-1:0]          pt_nxt;
    logic [PT_SZ-BURST_SZ-1:0] pair;

    assign pt_nxt = pt_q + PT_SZ'(1);
    assign pair   = pt_nxt[PT_SZ-1:BURST_SZ];

    always_comb begin
        state_d     = state_q;
        pt_d        = pt_q;
        hits_d      = hits_q;
        cand_d      = cand_q;
        start_row_d = '0;
        coord_en_d  = 1'b0;
        valid_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d     = S_LOAD;
                    coord_en_d  = 1'b1;
                    start_row_d = ROW_SZ'(1);
                    cand_d      = '0;
                end
            end
            S_LOAD: begin
                pt_d    = '0;
                hits_d  = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                hits_d = hits_q + CNT_SZ'(hit_i);
                pt_d   = pt_nxt;
                if (&pt_q) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    cand_d  = hits_q + CNT_SZ'(hit_i);
                end else if ((&pt_nxt[BURST_SZ-1:0]) && !(&pt_nxt)) begin
                    // Strobe lands on the last point of a burst so the next pair follows with no gap.
                    coord_en_d  = 1'b1;
                    start_row_d = ROW_SZ'({pair, 1'b1}) + ROW_SZ'(2);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            pt_q        <= '0;
            hits_q      <= '0;
            start_row_q <= '0;
            coord_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            cand_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pt_q        <= pt_d;
            hits_q      <= hits_d;
            start_row_q <= start_row_d;
            coord_en_q  <= coord_en_d;
            busy_q      <= busy_d;
            cand_q      <= cand_d;
            valid_q     <= valid_d;
        end
    end

    assign start_row_o = start_row_q;
    assign coord_en_o  = coord_en_q;
    assign busy_o      = busy_q;
    assign candidate_o = cand_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl with a behavioural coord_gen in the loop.
module tb_scan_ctrl;
    import scan_ctrl_pkg::*;

    localparam int unsigned CNT_SZ = DEF_CNT_SZ;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              en_i  = 1'b0;
    logic              hit_i;
    logic [ROW_SZ-1:0] start_row_o;
    logic              coord_en_o;
    logic              busy_o;
    logic [CNT_SZ-1:0] candidate_o;
    logic              valid_o;

    scan_ctrl #(
        .GRID_DIM (DEF_GRID_DIM),
        .CNT_SZ   (CNT_SZ)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .hit_i       (hit_i),
        .start_row_o (start_row_o),
        .coord_en_o  (coord_en_o),
        .busy_o      (busy_o),
        .candidate_o (candidate_o),
        .valid_o     (valid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t strobe_q[$];
    exp_t valid_q[$];
    exp_t mon_e;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural coord_gen: two rows of GRID_DIM points after each load strobe.
    logic       gv;
    logic [3:0] gx, gy, gbase;
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gv <= 1'b0; gx <= '0; gy <= '0; gbase <= '0;
        end else if (coord_en_o) begin
            gv <= 1'b1; gx <= 4'd1; gy <= start_row_o; gbase <= start_row_o;
        end else if (gv) begin
            if (gx == 4'd8) begin
                gx <= 4'd1;
                if (gy == gbase + 4'd1) gv <= 1'b0;
                else gy <= gy + 4'd1;
            end else begin
                gx <= gx + 4'd1;
            end
        end
    end

    int hit_mode = 0; // 0 none, 1 all, 2 x<=4 && y<=4
    always @* hit_i = (hit_mode == 1) || (hit_mode == 2 && gv && gx <= 4'd4 && gy <= 4'd4);

    int seen[8][8];
    int seen_bad = 0;
    bit pat_on   = 1'b0;
    always @(negedge clk_i) begin
        if (pat_on && gv) begin
            if (gx >= 4'd1 && gx <= 4'd8 && gy >= 4'd1 && gy <= 4'd8)
                seen[int'(gx) - 1][int'(gy) - 1]++;
            else
                seen_bad++;
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (coord_en_o) begin
                if (strobe_q.size() == 0) begin
                    check("strobe_unexpected", 32'(coord_en_o), 0);
                end else begin
                    mon_e = strobe_q.pop_front();
                    check("strobe_cycle", cyc, mon_e.cyc);
                    check("strobe_row", 32'(start_row_o), mon_e.val);
                end
            end else if (start_row_o != '0) begin
                check("row_zero_when_idle", 32'(start_row_o), 0);
            end
            if (valid_o) begin
                if (valid_q.size() == 0) begin
                    check("valid_unexpected", 32'(valid_o), 0);
                end else begin
                    mon_e = valid_q.pop_front();
                    check("valid_cycle", cyc, mon_e.cyc);
                    check("candidate", 32'(candidate_o), mon_e.val);
                end
            end
        end
    end

    task automatic push_scan(input int c0, input int cand);
        for (int i = 0; i < 4; i++) strobe_q.push_back('{cyc: c0 + 16 * i, val: 2 * i + 1});
        valid_q.push_back('{cyc: c0 + 65, val: cand});
    endtask

    task automatic start_scan(input int mode, input int cand, output int c0);
        @(negedge clk_i);
        hit_mode = mode;
        en_i     = 1'b1;
        c0       = cyc + 1;
        push_scan(c0, cand);
        @(negedge clk_i);
        en_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        do begin
            @(negedge clk_i);
            #1;
            n++;
        end while ((strobe_q.size() + valid_q.size()) != 0 && n < 300);
        check(tag, strobe_q.size() + valid_q.size(), 0);
    endtask

    initial begin
        int c0;
        int ok_cells;

        // Reset held, then idle with en_i low
        repeat (3) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_coord_en", 32'(coord_en_o), 0);
        rst_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check("idle_busy", 32'(busy_o), 0);
        check("idle_valid", 32'(valid_o), 0);
        check("idle_candidate", 32'(candidate_o), 0);
        check("idle_row", 32'(start_row_o), 0);

        // Full scan, every point hits
        start_scan(1, 64, c0);
        check("busy_in_load", 32'(busy_o), 1);
        wait_drain("all_hits_drain");
        repeat (3) @(negedge clk_i);
        check("candidate_hold", 32'(candidate_o), 64);
        check("busy_after_done", 32'(busy_o), 0);

        // Quadrant pattern with coord_gen in loop
        for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) seen[x][y] = 0;
        pat_on = 1'b1;
        start_scan(2, 16, c0);
        wait_drain("pattern_drain");
        pat_on = 1'b0;
        ok_cells = 0;
        for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) if (seen[x][y] == 1) ok_cells++;
        check("grid_each_once", ok_cells, 64);
        check("grid_out_of_range", seen_bad, 0);

        // Second command at point 20 must be ignored
        start_scan(2, 16, c0);
        while (cyc < c0 + 21) @(negedge clk_i);
        en_i = 1'b1;
        @(negedge clk_i);
        en_i = 1'b0;
        wait_drain("busy_cmd_drain");
        repeat (80) @(negedge clk_i);
        check("busy_cmd_candidate", 32'(candidate_o), 16);

        // Reset at point 40, then a fresh scan
        start_scan(1, 64, c0);
        while (cyc < c0 + 41) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_candidate", 32'(candidate_o), 0);
        check("midrst_coord_en", 32'(coord_en_o), 0);
        strobe_q.delete();
        valid_q.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_busy", 32'(busy_o), 0);
        start_scan(1, 64, c0);
        wait_drain("post_rst_drain");

        // en_i held high: two scans 67 cycles apart, no hits then all hits
        @(negedge clk_i);
        hit_mode = 0;
        en_i     = 1'b1;
        c0       = cyc + 1;
        push_scan(c0, 0);
        push_scan(c0 + 67, 64);
        while (cyc < c0 + 67) @(negedge clk_i);
        hit_mode = 1;
        en_i     = 1'b0;
        wait_drain("b2b_drain");
        repeat (5) @(negedge clk_i);
        check("b2b_candidate", 32'(candidate_o), 64);
        check("b2b_idle", 32'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
